// File: rtl/cond_pkg.sv
// Shared types for the execute-to-writeback condition stage.
// Holds condition codes, flag bit indices and the flag bundle.
package cond_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

endpackage

// File: rtl/cond_check.sv
// Combinational condition evaluator: condition field vs architectural flags.
// Code 1111 behaves as always.
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  flags_t     flags,
    output logic       cond_ex
);

    always_comb begin
        cond_ex = 1'b1;
        unique case (cond_e'(cond))
            COND_EQ: cond_ex = flags.z;
            COND_NE: cond_ex = !flags.z;
            COND_CS: cond_ex = flags.c;
            COND_CC: cond_ex = !flags.c;
            COND_MI: cond_ex = flags.n;
            COND_PL: cond_ex = !flags.n;
            COND_VS: cond_ex = flags.v;
            COND_VC: cond_ex = !flags.v;
            COND_HI: cond_ex = flags.c && !flags.z;
            COND_LS: cond_ex = !flags.c || flags.z;
            COND_GE: cond_ex = (flags.n == flags.v);
            COND_LT: cond_ex = (flags.n != flags.v);
            COND_GT: cond_ex = !flags.z && (flags.n == flags.v);
            COND_LE: cond_ex = flags.z || (flags.n != flags.v);
            COND_AL: cond_ex = 1'b1;
            COND_NV: cond_ex = 1'b1;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Execute-to-writeback condition stage: flag register, control gating,
// registered writeback slot and saturating skipped-instruction counter.
module cond_unit
    import cond_pkg::*;
#(
    parameter logic [3:0] FLAG_RESET = 4'b0000,
    parameter int         CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_e,
    input  logic             stall,
    input  logic             flush,
    input  logic [3:0]       cond,
    input  logic [3:0]       alu_flags,
    input  logic [31:0]      alu_result,
    input  logic [1:0]       flag_w,
    input  logic             pcs,
    input  logic             reg_w,
    input  logic             mem_w,
    output logic [3:0]       flags,
    output logic             cond_ex,
    output logic             pc_src,
    output logic             mem_write,
    output logic             valid_w,
    output logic             reg_write_w,
    output logic             pc_src_w,
    output logic [31:0]      result_w,
    output logic [CNT_W-1:0] skip_cnt
);

    flags_t flags_q, flags_d;
    logic valid_q, valid_d;
    logic reg_write_q, reg_write_d;
    logic pc_src_q, pc_src_d;
    logic [31:0] result_q, result_d;
    logic [CNT_W-1:0] skip_q, skip_d;
    logic fire, take;

    cond_check u_check (
        .cond    (cond),
        .flags   (flags_q),
        .cond_ex (cond_ex)
    );

    assign fire      = valid_e && !stall && !flush;
    assign take      = fire && cond_ex;
    assign pc_src    = take && pcs;
    assign mem_write = take && mem_w;

    always_comb begin
        flags_d = flags_q;
        if (take && flag_w[1]) begin
            flags_d.n = alu_flags[FLAG_N];
            flags_d.z = alu_flags[FLAG_Z];
        end
        if (take && flag_w[0]) begin
            flags_d.c = alu_flags[FLAG_C];
            flags_d.v = alu_flags[FLAG_V];
        end
    end

    // Stall freezes the whole writeback slot, even for a flushed instruction.
    always_comb begin
        valid_d     = valid_q;
        reg_write_d = reg_write_q;
        pc_src_d    = pc_src_q;
        result_d    = result_q;
        if (!stall) begin
            valid_d     = fire;
            reg_write_d = take && reg_w;
            pc_src_d    = take && pcs;
            result_d    = alu_result;
        end
    end

    always_comb begin
        skip_d = skip_q;
        if (fire && !cond_ex && (skip_q != {CNT_W{1'b1}})) begin
            skip_d = skip_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q     <= flags_t'(FLAG_RESET);
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            pc_src_q    <= 1'b0;
            result_q    <= 32'h0;
            skip_q      <= '0;
        end else begin
            flags_q     <= flags_d;
            valid_q     <= valid_d;
            reg_write_q <= reg_write_d;
            pc_src_q    <= pc_src_d;
            result_q    <= result_d;
            skip_q      <= skip_d;
        end
    end

    assign flags       = flags_q;
    assign valid_w     = valid_q;
    assign reg_write_w = reg_write_q;
    assign pc_src_w    = pc_src_q;
    assign result_w    = result_q;
    assign skip_cnt    = skip_q;

endmodule

// File: doc/cond_unit.md
# cond_unit

Execute-to-writeback condition stage that consumes the ALU's `{N,Z,C,V}` flags. It holds the architectural flag register and evaluates the instruction's 4-bit condition field against it. From that result it gates the side-effecting control signals, and it carries the ALU result into a registered writeback slot with stall/flush handling. A saturating counter tracks condition-failed (skipped) instructions for debug.

## Interface
- `FLAG_RESET`, default 4'b0000: reset value of the flag register `{N,Z,C,V}`
- `CNT_W`, default 16: width of the skip counter
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `valid_e`  in  1  execute-stage instruction valid
- `stall`  in  1  hold the stage; no state change, no side effects
- `flush`  in  1  kill the execute-stage instruction
- `cond`  in  4  instruction condition field
- `alu_flags`  in  4  `{N,Z,C,V}` from ALU, same cycle
- `alu_result`  in  32  ALU result, same cycle
- `flag_w`  in  2  bit1 updates N,Z; bit0 updates C,V
- `pcs`, `reg_w`, `mem_w`  in  1 each  ungated decoder controls
- `flags`  out  4  current architectural flags
- `cond_ex`  out  1  condition passes (combinational)
- `pc_src`, `mem_write`  out  1 each  gated execute-stage controls (combinational)
- `valid_w`, `reg_write_w`, `pc_src_w`  out  1 each  registered writeback controls
- `result_w`  out  32  registered ALU result
- `skip_cnt`  out  `CNT_W`  saturating count of condition-failed instructions

## Operation
- `cond_ex` is evaluated against the flag register, not against `alu_flags`.
- Condition codes:
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C
  - 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V
  - 1000 HI C&!Z; 1001 LS !C|Z
  - 1010 GE N==V; 1011 LT N!=V
  - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V)
  - 1110 AL 1; 1111 is treated as 1
- `fire = valid_e & !stall & !flush`; `take = fire & cond_ex`.
- Gated execute-stage controls: `pc_src = take & pcs`; `mem_write = take & mem_w`.
- Flag update on a clock edge when `take`:
  - `flag_w[1]` loads N,Z from `alu_flags[3:2]`.
  - `flag_w[0]` loads C,V from `alu_flags[1:0]`.
  - Bits not selected by `flag_w` hold.
- Writeback register:
  - On `stall`: all writeback registers hold.
  - Otherwise: `valid_w <= fire`, `reg_write_w <= take & reg_w`, `pc_src_w <= take & pcs`, `result_w <= alu_result`.
  - When `!fire`, `result_w` also loads `alu_result`, but it is don't-care because `valid_w` = 0.
- Skip counter: increments when `fire & !cond_ex`; saturates at all-ones.
- Precedence:
  - `flush` beats `stall` for execute-stage gating: both combinational gated outputs are 0.
  - With `stall` = 1, the writeback registers still hold.

## Timing
- Reset (async assert, sync-to-clk deassert is external): `flags` = FLAG_RESET; `valid_w`, `reg_write_w`, `pc_src_w` = 0; `result_w` = 0; `skip_cnt` = 0.
- Combinational outputs after reset follow from the reset flags.
- Latency:
  - `cond_ex`, `pc_src`, `mem_write`: 0 cycles.
  - Writeback outputs: 1 cycle.
  - Flag update is visible to `cond_ex` on the next cycle.
- Back-to-back: an instruction setting flags in cycle n is seen by the instruction in cycle n+1. There is no forwarding from `alu_flags`.
- Reset asserted mid-operation clears all state immediately. An in-flight writeback instruction is dropped.
- `stall` held for k cycles produces no flag change, no counter change and no gated pulses. Outputs resume on the first unstalled cycle.

## Structure
- Package `cond_pkg` holds:
  - `cond_e` enum with the 16 codes.
  - Flag bit index constants `FLAG_N=3`, `FLAG_Z=2`, `FLAG_C=1`, `FLAG_V=0`.
  - `flags_t` packed struct `{n,z,c,v}`.
- Sub-module `cond_check`: purely combinational; (`cond`, `flags`) -> `cond_ex`. It is instanced once.

## Test plan
- Reset, then `cond`=EQ with `FLAG_RESET`=0 -> `cond_ex`=0, `skip_cnt`=1 after the edge. Repeat with `cond`=AL -> `cond_ex`=1.
- SUB with `alu_flags`=4'b0110, `flag_w`=2'b11, AL; next cycle BEQ `pcs`=1 -> `pc_src`=1, `flags`=4'b0110.
- `flag_w`=2'b10 with `alu_flags`=4'b1011 from `flags`=4'b0000 -> `flags`=4'b1000 (C,V held). Next GE -> 0; LT -> 1.
- STR with `mem_w`=1, AL, `stall`=1 for 3 cycles -> `mem_write`=0 and writeback held throughout. Stall released -> `mem_write`=1 for one cycle, `valid_w`=1 next cycle.
- `flush`=1 with AL, `reg_w`=1, `flag_w`=2'b11 -> no flag change, `valid_w`=0, `reg_write_w`=0, `skip_cnt` unchanged.
- Force `skip_cnt` near max (`CNT_W`=4: 15 failed instructions, then 2 more) -> `skip_cnt` stays 4'hF. Assert `rst_n`=0 mid-cycle -> all outputs reset asynchronously.
